// File: rtl/cache_controller.sv
// 2-way set-associative, write-through, no-write-allocate data cache in front of SRAM_Controller.
// Define CACHE_STATS_EN to add saturating read hit/miss counters (hit_count, miss_count).
module cache_controller #(
    parameter int SETS      = 64,
    parameter int TAG_W     = 10,
    parameter int BASE_ADDR = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_rd_en,
    input  logic        mem_wr_en,
    input  logic [31:0] mem_address,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        ready,
    output logic        sram_rd_en,
    output logic        sram_wr_en,
    output logic [31:0] sram_address,
    output logic [31:0] sram_wdata,
    input  logic [31:0] sram_rdata,
    input  logic        sram_ready
`ifdef CACHE_STATS_EN
    ,
    output logic [15:0] hit_count,
    output logic [15:0] miss_count
`endif
);
    localparam int INDEX_W = $clog2(SETS);

    typedef enum logic [1:0] {IDLE, RD_W0, RD_W1, WRITE} state_t;
    state_t state, state_next;

    logic [63:0]      data_q  [2][SETS];
    logic [TAG_W-1:0] tag_q   [2][SETS];
    logic             valid_q [2][SETS];
    logic             lru_q   [SETS];

    logic [31:0]        off, w0_q, hit_word;
    logic               word_sel, hit0, hit1, hit, hit_way, victim;
    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   tag_in;
    logic               armed, done;
    logic               start_rd, start_wr, do_hit_lru, do_wr_upd, do_fill;
    logic               unused_off;

    assign off        = mem_address - 32'(BASE_ADDR);
    assign word_sel   = off[2];
    assign idx        = off[INDEX_W+2:3];
    assign tag_in     = off[TAG_W+INDEX_W+2:INDEX_W+3];
    assign unused_off = ^{off[31:TAG_W+INDEX_W+3], off[1:0]};

    assign hit0     = valid_q[0][idx] && (tag_q[0][idx] == tag_in);
    assign hit1     = valid_q[1][idx] && (tag_q[1][idx] == tag_in);
    assign hit      = hit0 | hit1;
    assign hit_way  = hit1;
    assign victim   = !valid_q[0][idx] ? 1'b0 : (!valid_q[1][idx] ? 1'b1 : lru_q[idx]);
    assign hit_word = word_sel ? data_q[hit_way][idx][63:32] : data_q[hit_way][idx][31:0];

    // The first enabled cycle of a request is never trusted; armed marks the cycles after it.
    assign done = armed && sram_ready && (sram_rd_en || sram_wr_en);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        ready      = 1'b1;
        mem_rdata  = '0;
        start_rd   = 1'b0;
        start_wr   = 1'b0;
        do_hit_lru = 1'b0;
        do_wr_upd  = 1'b0;
        do_fill    = 1'b0;
        case (state)
            IDLE: begin
                if (mem_wr_en) begin
                    ready      = 1'b0;
                    start_wr   = 1'b1;
                    state_next = WRITE;
                end else if (mem_rd_en) begin
                    if (hit) begin
                        mem_rdata  = hit_word;
                        do_hit_lru = 1'b1;
                    end else begin
                        ready      = 1'b0;
                        start_rd   = 1'b1;
                        state_next = RD_W0;
                    end
                end
            end
            RD_W0: begin
                ready = 1'b0;
                if (done) state_next = RD_W1;
            end
            RD_W1: begin
                ready = 1'b0;
                if (done) begin
                    ready      = 1'b1;
                    mem_rdata  = word_sel ? sram_rdata : w0_q;
                    do_fill    = 1'b1;
                    state_next = IDLE;
                end
            end
            WRITE: begin
                ready = 1'b0;
                if (done) begin
                    ready      = 1'b1;
                    do_wr_upd  = hit;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // RD_W0 -> RD_W1 drops the enable for one cycle so SRAM_Controller sees a fresh request.
    always_ff @(posedge clk) begin
        if (rst) begin
            sram_rd_en   <= 1'b0;
            sram_wr_en   <= 1'b0;
            sram_address <= '0;
            sram_wdata   <= '0;
            armed        <= 1'b0;
            w0_q         <= '0;
        end else if (state == IDLE) begin
            armed <= 1'b0;
            if (start_wr) begin
                sram_wr_en   <= 1'b1;
                sram_address <= mem_address;
                sram_wdata   <= mem_wdata;
            end else if (start_rd) begin
                sram_rd_en   <= 1'b1;
                sram_address <= {mem_address[31:3], 3'b000};
            end
        end else if (!(sram_rd_en || sram_wr_en)) begin
            if (state == WRITE) sram_wr_en <= 1'b1;
            else                sram_rd_en <= 1'b1;
            armed <= 1'b0;
        end else if (!armed) begin
            armed <= 1'b1;
        end else if (sram_ready) begin
            sram_rd_en <= 1'b0;
            sram_wr_en <= 1'b0;
            armed      <= 1'b0;
            if (state == RD_W0) begin
                w0_q         <= sram_rdata;
                sram_address <= sram_address + 32'd4;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned s = 0; s < SETS; s++) begin
                valid_q[0][s] <= 1'b0;
                valid_q[1][s] <= 1'b0;
                lru_q[s]      <= 1'b0;
            end
        end else begin
            if (do_hit_lru || do_wr_upd) lru_q[idx] <= ~hit_way;
            if (do_fill) begin
                valid_q[victim][idx] <= 1'b1;
                lru_q[idx]           <= ~victim;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && do_fill) begin
            tag_q[victim][idx]  <= tag_in;
            data_q[victim][idx] <= {sram_rdata, w0_q};
        end
        if (!rst && do_wr_upd) begin
            if (word_sel) data_q[hit_way][idx][63:32] <= mem_wdata;
            else          data_q[hit_way][idx][31:0]  <= mem_wdata;
        end
    end

`ifdef CACHE_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (do_hit_lru && hit_count != '1)  hit_count  <= hit_count + 16'd1;
            if (start_rd && miss_count != '1)   miss_count <= miss_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cache_controller.sv
// Self-checking bench for cache_controller: SRAM_Controller model plus a true-LRU reference cache.
module tb_cache_controller;
    logic        clk = 1'b0;
    logic        rst, mem_rd_en, mem_wr_en, ready, sram_rd_en, sram_wr_en, sram_ready;
    logic [31:0] mem_address, mem_wdata, mem_rdata, sram_address, sram_wdata, sram_rdata;
`ifdef CACHE_STATS_EN
    logic [15:0] hit_count, miss_count;
`endif

    always #5 clk = ~clk;

    cache_controller #(.SETS(64), .TAG_W(10), .BASE_ADDR(1024)) dut (
        .clk(clk), .rst(rst),
        .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
        .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .ready(ready),
        .sram_rd_en(sram_rd_en), .sram_wr_en(sram_wr_en),
        .sram_address(sram_address), .sram_wdata(sram_wdata),
        .sram_rdata(sram_rdata), .sram_ready(sram_ready)
`ifdef CACHE_STATS_EN
        , .hit_count(hit_count), .miss_count(miss_count)
`endif
    );

    int checks = 0;
    int failures = 0;
    int exp_hits = 0;
    int exp_misses = 0;
    int unsigned lat = 3;

    // SRAM_Controller model: ready one cycle after lat enabled cycles; enable left high after ready is an error.
    logic [31:0] smem [int unsigned];
    logic [31:0] rlog[$];
    logic [31:0] wlog_addr[$];
    logic [31:0] wlog_data[$];
    int unsigned cnt;
    logic ready_d, rd_prev;
    int proto_err = 0;

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0000 ^ {a[15:0], 16'h0000};
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            cnt <= 0; sram_ready <= 1'b0; ready_d <= 1'b0; rd_prev <= 1'b0; sram_rdata <= '0;
        end else begin
            ready_d <= sram_ready;
            rd_prev <= sram_rd_en;
            if (ready_d && (sram_rd_en || sram_wr_en)) proto_err <= proto_err + 1;
            if (sram_rd_en && !rd_prev) rlog.push_back(sram_address);
            if (sram_ready) begin
                sram_ready <= 1'b0;
                cnt <= 0;
            end else if (sram_rd_en || sram_wr_en) begin
                if (cnt + 1 >= lat) begin
                    sram_ready <= 1'b1;
                    cnt <= 0;
                    if (sram_wr_en) begin
                        smem[sram_address] = sram_wdata;
                        wlog_addr.push_back(sram_address);
                        wlog_data.push_back(sram_wdata);
                    end else begin
                        sram_rdata <= smem.exists(sram_address) ? smem[sram_address] : init_word(sram_address);
                    end
                end else begin
                    cnt <= cnt + 1;
                end
            end else begin
                cnt <= 0;
            end
        end
    end

    // Reference: per set, up to two resident tags ordered most-recent first; memory image kept separately.
    int          rn [64];
    int unsigned rtag [64][2];
    logic [31:0] ref_mem [int unsigned];

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    function automatic bit ref_touch(input logic [31:0] a, input bit allocate);
        int unsigned o, s, t, tmp;
        o = a - 1024;
        s = (o >> 3) % 64;
        t = (o >> 9) % 1024;
        for (int i = 0; i < rn[s]; i++) begin
            if (rtag[s][i] == t) begin
                if (i == 1) begin
                    tmp = rtag[s][0]; rtag[s][0] = rtag[s][1]; rtag[s][1] = tmp;
                end
                return 1'b1;
            end
        end
        if (allocate) begin
            rtag[s][1] = rtag[s][0];
            rtag[s][0] = t;
            if (rn[s] < 2) rn[s]++;
        end
        return 1'b0;
    endfunction

    task automatic ref_clear();
        for (int s = 0; s < 64; s++) rn[s] = 0;
        exp_hits = 0;
        exp_misses = 0;
    endtask

    task automatic check_read(input logic [31:0] a);
        bit          exp_hit, hit_now;
        logic [31:0] exp_d;
        int          cyc;
        exp_d   = ref_word(a);
        exp_hit = ref_touch(a, 1'b1);
        rlog.delete();
        @(negedge clk);
        mem_rd_en = 1'b1; mem_wr_en = 1'b0; mem_address = a;
        #1;
        hit_now = ready;
        cyc = 0;
        while (!ready && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (!ready) begin
            failures++; $display("FAIL read_timeout addr=%h ready=%b required=1", a, ready);
        end
        checks++;
        if (hit_now !== exp_hit) begin
            failures++; $display("FAIL read_hit addr=%h got=%b required=%b", a, hit_now, exp_hit);
        end
        checks++;
        if (mem_rdata !== exp_d) begin
            failures++; $display("FAIL read_data addr=%h got=%h required=%h", a, mem_rdata, exp_d);
        end
        @(posedge clk); #1;
        mem_rd_en = 1'b0;
        checks++;
        if (exp_hit ? (rlog.size() != 0)
                    : (rlog.size() != 2 || rlog[0] !== {a[31:3], 3'b000} || rlog[1] !== {a[31:3], 3'b100})) begin
            failures++;
            $display("FAIL read_sram_seq addr=%h got_pulses=%0d first=%h required_pulses=%0d",
                     a, rlog.size(), (rlog.size() > 0) ? rlog[0] : 32'hx, exp_hit ? 0 : 2);
        end
        if (exp_hit) exp_hits++; else exp_misses++;
    endtask

    task automatic check_write(input logic [31:0] a, input logic [31:0] d, input bit both);
        bit stalled;
        int cyc;
        bit unused_hit;
        ref_mem[a] = d;
        unused_hit = ref_touch(a, 1'b0);
        wlog_addr.delete(); wlog_data.delete();
        @(negedge clk);
        mem_wr_en = 1'b1; mem_rd_en = both; mem_address = a; mem_wdata = d;
        #1;
        stalled = !ready;
        cyc = 0;
        while (!ready && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (!stalled || !ready) begin
            failures++; $display("FAIL write_stall addr=%h stalled=%b ready_at_end=%b required=1/1", a, stalled, ready);
        end
        @(posedge clk); #1;
        mem_wr_en = 1'b0; mem_rd_en = 1'b0;
        checks++;
        if (wlog_addr.size() != 1 || wlog_addr[0] !== a || wlog_data[0] !== d) begin
            failures++;
            $display("FAIL write_sram addr=%h writes=%0d got_addr=%h got_data=%h required=1 %h %h",
                     a, wlog_addr.size(), (wlog_addr.size() > 0) ? wlog_addr[0] : 32'hx,
                     (wlog_data.size() > 0) ? wlog_data[0] : 32'hx, a, d);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        checks++;
        if (ready !== 1'b1 || sram_rd_en !== 1'b0 || sram_wr_en !== 1'b0 || mem_rdata !== 32'h0) begin
            failures++;
            $display("FAIL %s ready=%b rd_en=%b wr_en=%b rdata=%h required=1 0 0 0", tag, ready, sram_rd_en, sram_wr_en, mem_rdata);
        end
`ifdef CACHE_STATS_EN
        checks++;
        if (hit_count !== 16'd0 || miss_count !== 16'd0) begin
            failures++; $display("FAIL %s_stats hit=%0d miss=%0d required=0 0", tag, hit_count, miss_count);
        end
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1; mem_rd_en = 1'b0; mem_wr_en = 1'b0; mem_address = '0; mem_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset_outputs");
        checks++;
        if (sram_address !== 32'h0 || sram_wdata !== 32'h0) begin
            failures++; $display("FAIL reset_sram_bus addr=%h wdata=%h required=0 0", sram_address, sram_wdata);
        end
        rst = 1'b0;
        ref_clear();
    endtask

    task automatic test_read_miss_hit();
        smem[1024] = 32'h1111_1111; ref_mem[1024] = 32'h1111_1111;
        smem[1028] = 32'h2222_2222; ref_mem[1028] = 32'h2222_2222;
        check_read(32'd1024);
        check_read(32'd1028);
    endtask

    task automatic test_lru();
        check_read(32'd1024);
        check_read(32'd1536);
        check_read(32'd1024);
        check_read(32'd2048);
        check_read(32'd1024);
        check_read(32'd1536);
    endtask

    task automatic test_write();
        check_write(32'd1028, 32'hDEAD_BEEF, 1'b0);
        check_read(32'd1028);
        check_write(32'd2560, 32'hCAFE_F00D, 1'b0);
        check_read(32'd2560);
    endtask

    task automatic test_random();
        logic [31:0] a;
        int unsigned op;
        for (int n = 0; n < 400; n++) begin
            lat = $urandom_range(1, 5);
            a  = 32'd1024 + (($urandom % 4) << 9) + (($urandom % 4) << 3) + (($urandom % 2) << 2);
            op = $urandom % 10;
            if (op < 6)      check_read(a);
            else if (op < 9) check_write(a, $urandom, 1'b0);
            else             check_write(a, $urandom, 1'b1);
        end
        lat = 3;
`ifdef CACHE_STATS_EN
        checks++;
        if (hit_count !== 16'(exp_hits) || miss_count !== 16'(exp_misses)) begin
            failures++;
            $display("FAIL stats_count hit=%0d miss=%0d required=%0d %0d", hit_count, miss_count, exp_hits, exp_misses);
        end
`endif
    endtask

    task automatic test_reset_mid();
        int cyc;
        lat = 4;
        rlog.delete();
        @(negedge clk);
        mem_rd_en = 1'b1; mem_wr_en = 1'b0; mem_address = 32'd3584;
        cyc = 0;
        while (!(sram_rd_en && sram_address == 32'd3588) && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (!(sram_rd_en && sram_address == 32'd3588)) begin
            failures++; $display("FAIL reset_mid_reach rd_en=%b addr=%h required=1 00000e04", sram_rd_en, sram_address);
        end
        rst = 1'b1; mem_rd_en = 1'b0;
        @(negedge clk);
        check_idle_outputs("reset_mid");
        rst = 1'b0;
        ref_clear();
        check_read(32'd1024);
        check_read(32'd1024);
    endtask

    task automatic test_protocol();
        checks++;
        if (proto_err != 0) begin
            failures++; $display("FAIL enable_after_ready count=%0d required=0", proto_err);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time_limit reached required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_read_miss_hit();
        test_lru();
        test_write();
        test_random();
        test_reset_mid();
        test_protocol();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
